rotate_ram_port: RTL and testbench

Memory-side responder for the scandoubler rotation path. It services 16-word write bursts on the vidin interface and 8-word read bursts on the vidout interface. Both are mapped onto a single word-wide RAM port with a req/ack handshake. It sits between the scandoubler's rotation stage and the SDRAM controller's video channel, and is the only block that turns frame/row/column positions into RAM word addresses.

---
 rtl/rotate_ram_port.sv | 222 ++++++++++++++++++++++
 tb/tb_rotate_ram_port.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rotate_ram_port.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rotate_ram_port                                              |
// | Description : Memory-side responder for the scandoubler rotation path.     |
// |               Turns 16-word vidin write bursts and 8-word vidout read      |
// |               bursts into single-word req/ack accesses on one RAM port.    |
// |               RAM word address = BASE_ADDR + {frame, row, col}.            |
// | Ports       : clk_sys, reset (sync, active high)                           |
// |               vidin_*  : write burst initiator (req/frame/row/col/d, ack)  |
// |               vidout_* : read initiator (req/frame/row/col, d/ack)         |
// |               ram_*    : word RAM port (req/we/addr/wdata, rdata/ack)      |
// | Config      : ROTATE_RAM_RR_ARB_EN defined   -> round-robin arbitration    |
// |               ROTATE_RAM_RR_ARB_EN undefined -> strict read priority       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rotate_ram_port #(
  parameter int                    ADDR_WIDTH = 24,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic                  vidin_req,
  input  logic [1:0]            vidin_frame,
  input  logic [10:0]           vidin_row,
  input  logic [10:0]           vidin_col,
  input  logic [15:0]           vidin_d,
  output logic                  vidin_ack,
  input  logic                  vidout_req,
  input  logic [1:0]            vidout_frame,
  input  logic [10:0]           vidout_row,
  input  logic [10:0]           vidout_col,
  output logic [15:0]           vidout_d,
  output logic                  vidout_ack,
  output logic                  ram_req,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [15:0]           ram_wdata,
  input  logic [15:0]           ram_rdata,
  input  logic                  ram_ack
);

  localparam logic [4:0] c_WR_WORDS = 5'd16;
  localparam logic [4:0] c_RD_LAST  = 5'd7;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WLOAD = 3'd1,
    S_WRITE = 3'd2,
    S_WACK  = 3'd3,
    S_READ  = 3'd4,
    S_WHOLD = 3'd5
  } state_t;

  state_t      r_state;
  logic [1:0]  r_frame;
  logic [10:0] r_row;
  logic [10:0] r_wcol;
  logic [10:0] r_rcol;
  logic [4:0]  r_count;
  logic        r_vreq_d;
  logic        r_rcol_pend;
  logic [10:0] r_rcol_next;

  logic                  w_vrise;
  logic                  w_rcol_load;
  logic [10:0]           w_rcol_src;
  logic [10:0]           w_rcol_inc;
  logic                  w_grant_rd;
  logic                  w_grant_wr;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [ADDR_WIDTH-1:0] w_raddr;
  logic [ADDR_WIDTH-1:0] w_raddr_next;

  // The 24-bit position is zero-extended and the base added modulo 2^ADDR_WIDTH.
  function automatic logic [ADDR_WIDTH-1:0] f_addr(input logic [1:0]  frame,
                                                   input logic [10:0] row,
                                                   input logic [10:0] col);
    logic [ADDR_WIDTH-1:0] lin;
    lin        = '0;
    lin[23:0]  = {frame, row, col};
    return lin + BASE_ADDR;
  endfunction

  // A new start column is captured on every vidout_req rising edge but only
  // applied when the FSM next grants a read, so an active burst keeps counting.
  assign w_vrise     = vidout_req & ~r_vreq_d;
  assign w_rcol_load = w_vrise | r_rcol_pend;
  assign w_rcol_src  = w_vrise ? vidout_col : r_rcol_next;
  assign w_rcol_inc  = r_rcol + 11'd1;

  assign w_waddr      = f_addr(r_frame, r_row, r_wcol);
  assign w_raddr      = f_addr(r_frame, r_row, r_rcol);
  assign w_raddr_next = f_addr(r_frame, r_row, w_rcol_inc);

`ifdef ROTATE_RAM_RR_ARB_EN
  // Last-grant flag: 1 = read was granted last.
  logic r_last_rd;

  assign w_grant_rd = vidout_req & (~vidin_req | ~r_last_rd);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_last_rd <= 1'b1;
    end else if (r_state == S_IDLE) begin
      if (w_grant_rd) begin
        r_last_rd <= 1'b1;
      end else if (w_grant_wr) begin
        r_last_rd <= 1'b0;
      end
    end
  end
`else
  assign w_grant_rd = vidout_req;
`endif

  assign w_grant_wr = vidin_req & ~w_grant_rd;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state     <= S_IDLE;
      ram_req     <= 1'b0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      vidin_ack   <= 1'b0;
      vidout_ack  <= 1'b0;
      vidout_d    <= '0;
      r_frame     <= '0;
      r_row       <= '0;
      r_wcol      <= '0;
      r_rcol      <= '0;
      r_count     <= '0;
      r_vreq_d    <= 1'b0;
      r_rcol_pend <= 1'b0;
      r_rcol_next <= '0;
    end else begin
      vidin_ack  <= 1'b0;
      vidout_ack <= 1'b0;
      r_vreq_d   <= vidout_req;

      if (w_vrise) begin
        r_rcol_pend <= 1'b1;
        r_rcol_next <= vidout_col;
      end

      case (r_state)
        S_IDLE: begin
          if (w_grant_rd) begin
            r_frame <= vidout_frame;
            r_row   <= vidout_row;
            r_count <= '0;
            if (w_rcol_load) begin
              r_rcol      <= w_rcol_src;
              r_rcol_pend <= 1'b0;
            end
            r_state <= S_READ;
          end else if (w_grant_wr) begin
            r_frame <= vidin_frame;
            r_row   <= vidin_row;
            r_wcol  <= vidin_col;
            r_count <= '0;
            r_state <= S_WLOAD;
          end
        end

        S_WLOAD: begin
          ram_wdata <= vidin_d;
          r_state   <= S_WRITE;
        end

        S_WRITE: begin
          if (!ram_req) begin
            ram_req  <= 1'b1;
            ram_we   <= 1'b1;
            ram_addr <= w_waddr;
          end else if (ram_ack) begin
            ram_req   <= 1'b0;
            vidin_ack <= 1'b1;
            r_count   <= r_count + 5'd1;
            r_wcol    <= r_wcol + 11'd1;
            r_state   <= S_WACK;
          end
        end

        S_WACK: begin
          r_state <= (r_count == c_WR_WORDS) ? S_WHOLD : S_WLOAD;
        end

        // ram_req stays high across words of a read burst; only the address
        // advances on each ack.
        S_READ: begin
          if (!ram_req) begin
            ram_req  <= 1'b1;
            ram_we   <= 1'b0;
            ram_addr <= w_raddr;
          end else if (ram_ack) begin
            vidout_d   <= ram_rdata;
            vidout_ack <= 1'b1;
            r_rcol     <= w_rcol_inc;
            r_count    <= r_count + 5'd1;
            if (r_count == c_RD_LAST) begin
              ram_req <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              ram_addr <= w_raddr_next;
            end
          end
        end

        S_WHOLD: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rotate_ram_port.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_rotate_ram_port                                           |
// | Description : Self-checking bench for rotate_ram_port with a RAM responder |
// |               and a word-level reference of the rotation buffer contents.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_rotate_ram_port;

  localparam int              AW   = 24;
  localparam logic [AW-1:0]   BASE = 24'hFF0000;
`ifdef ROTATE_RAM_RR_ARB_EN
  localparam bit              RR   = 1'b1;
`else
  localparam bit              RR   = 1'b0;
`endif

  logic          clk_sys      = 1'b0;
  logic          reset        = 1'b1;
  logic          vidin_req    = 1'b0;
  logic [1:0]    vidin_frame  = '0;
  logic [10:0]   vidin_row    = '0;
  logic [10:0]   vidin_col    = '0;
  logic [15:0]   vidin_d      = '0;
  logic          vidin_ack;
  logic          vidout_req   = 1'b0;
  logic [1:0]    vidout_frame = '0;
  logic [10:0]   vidout_row   = '0;
  logic [10:0]   vidout_col   = '0;
  logic [15:0]   vidout_d;
  logic          vidout_ack;
  logic          ram_req;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [15:0]   ram_wdata;
  logic [15:0]   ram_rdata    = '0;
  logic          ram_ack      = 1'b0;

  always #5 clk_sys = ~clk_sys;

  rotate_ram_port #(
    .ADDR_WIDTH (AW),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .vidin_req    (vidin_req),
    .vidin_frame  (vidin_frame),
    .vidin_row    (vidin_row),
    .vidin_col    (vidin_col),
    .vidin_d      (vidin_d),
    .vidin_ack    (vidin_ack),
    .vidout_req   (vidout_req),
    .vidout_frame (vidout_frame),
    .vidout_row   (vidout_row),
    .vidout_col   (vidout_col),
    .vidout_d     (vidout_d),
    .vidout_ack   (vidout_ack),
    .ram_req      (ram_req),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata),
    .ram_ack      (ram_ack)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  // RAM storage, reference contents, transaction log.
  logic [15:0] ram_mem   [int];
  logic [15:0] model_mem [int];
  int          log_we    [$];
  int          log_addr  [$];
  int          log_data  [$];
  logic [15:0] rd_data   [$];
  int          resp_lat  = 2;
  bit          resp_en   = 1'b1;
  bit          stray_req = 1'b0;

  function automatic int exp_addr(input int f, input int r, input int c);
    longint a;
    a = longint'(BASE) + longint'(f) * 4194304 + longint'(r) * 2048 + longint'(c % 2048);
    return int'(a % 64'd16777216);
  endfunction

  function automatic logic [15:0] fill(input int a);
    return 16'(a ^ (a >> 9)) ^ 16'hA5C3;
  endfunction

  function automatic logic [15:0] exp_word(input int a);
    return model_mem.exists(a) ? model_mem[a] : fill(a);
  endfunction

  function automatic int lg_we(input int i);   return (i < log_we.size())   ? log_we[i]   : -1; endfunction
  function automatic int lg_addr(input int i); return (i < log_addr.size()) ? log_addr[i] : -1; endfunction
  function automatic int lg_data(input int i); return (i < log_data.size()) ? log_data[i] : -1; endfunction
  function automatic int rd_at(input int i);   return (i < rd_data.size())  ? int'(rd_data[i]) : -1; endfunction

  // RAM responder: acks after resp_lat cycles of ram_req high, one-cycle pulse.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk_sys);
      if (ram_ack) begin
        ram_ack = 1'b0;
      end else if (stray_req) begin
        stray_req = 1'b0;
        ram_ack   = 1'b1;
      end else if (resp_en && ram_req) begin
        cnt++;
        if (cnt >= resp_lat) begin
          cnt = 0;
          log_we.push_back(int'(ram_we));
          log_addr.push_back(int'(ram_addr));
          if (ram_we) begin
            ram_mem[int'(ram_addr)] = ram_wdata;
            log_data.push_back(int'(ram_wdata));
          end else begin
            ram_rdata = ram_mem.exists(int'(ram_addr)) ? ram_mem[int'(ram_addr)] : fill(int'(ram_addr));
            log_data.push_back(int'(ram_rdata));
          end
          ram_ack = 1'b1;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic clear_log();
    log_we.delete();
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    reset = 1'b1;
    repeat (2) @(negedge clk_sys);
    reset = 1'b0;
  endtask

  // Write initiator: 16 random words; reference contents updated up front.
  task automatic run_write(input int f, input int r, input int c, input int gap_exp,
                           output int acks, output int gaps_bad);
    logic [15:0] w [16];
    int last;
    for (int i = 0; i < 16; i++) begin
      w[i] = 16'($urandom);
      model_mem[exp_addr(f, r, c + i)] = w[i];
    end
    acks = 0; gaps_bad = 0; last = -1;
    @(negedge clk_sys);
    vidin_frame = 2'(f); vidin_row = 11'(r); vidin_col = 11'(c);
    vidin_d = w[0]; vidin_req = 1'b1;
    for (int t = 0; t < 4000 && acks < 16; t++) begin
      @(negedge clk_sys);
      if (vidin_ack) begin
        if (gap_exp > 0 && last >= 0 && (cyc - last) != gap_exp) gaps_bad++;
        last = cyc;
        acks++;
        if (acks == 16) vidin_req = 1'b0;
        else            vidin_d = w[acks];
      end
    end
    vidin_req = 1'b0;
  endtask

  // Read initiator: holds vidout_req until drop_after words, waits for expect_n.
  task automatic run_read(input int f, input int r, input int c, input int drop_after,
                          input int expect_n, output int got);
    rd_data.delete();
    got = 0;
    @(negedge clk_sys);
    vidout_frame = 2'(f); vidout_row = 11'(r); vidout_col = 11'(c);
    vidout_req = 1'b1;
    for (int t = 0; t < 4000 && got < expect_n; t++) begin
      @(negedge clk_sys);
      if (vidout_ack) begin
        rd_data.push_back(vidout_d);
        got++;
        if (got == drop_after) vidout_req = 1'b0;
      end
    end
    vidout_req = 1'b0;
    repeat (20) begin
      @(negedge clk_sys);
      if (vidout_ack) got++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_sys);
    checks++; if (ram_req !== 1'b0)    begin errors++; $display("FAIL reset_ram_req got %b exp 0", ram_req); end
    checks++; if (ram_we !== 1'b0)     begin errors++; $display("FAIL reset_ram_we got %b exp 0", ram_we); end
    checks++; if (ram_addr !== '0)     begin errors++; $display("FAIL reset_ram_addr got %h exp 0", ram_addr); end
    checks++; if (ram_wdata !== '0)    begin errors++; $display("FAIL reset_ram_wdata got %h exp 0", ram_wdata); end
    checks++; if (vidin_ack !== 1'b0)  begin errors++; $display("FAIL reset_vidin_ack got %b exp 0", vidin_ack); end
    checks++; if (vidout_ack !== 1'b0) begin errors++; $display("FAIL reset_vidout_ack got %b exp 0", vidout_ack); end
    checks++; if (vidout_d !== '0)     begin errors++; $display("FAIL reset_vidout_d got %h exp 0", vidout_d); end
    reset = 1'b0;
  endtask

  task automatic test_write_burst(input int f, input int r, input int c, input int lat);
    int acks, gb;
    clear_log();
    resp_lat = lat;
    run_write(f, r, c, 3 + lat, acks, gb);
    checks++; if (acks != 16) begin errors++; $display("FAIL wr_acks c=%0d got %0d exp 16", c, acks); end
    checks++; if (gb != 0)    begin errors++; $display("FAIL wr_ack_spacing got %0d bad gaps exp 0 (gap %0d)", gb, 3 + lat); end
    repeat (10) @(negedge clk_sys);
    checks++; if (log_addr.size() != 16) begin errors++; $display("FAIL wr_txn_count got %0d exp 16", log_addr.size()); end
    for (int i = 0; i < 16; i++) begin
      int a;
      a = exp_addr(f, r, c + i);
      checks++;
      if (lg_we(i) != 1 || lg_addr(i) != a || lg_data(i) != int'(model_mem[a])) begin
        errors++;
        $display("FAIL wr_txn[%0d] got we=%0d addr=%0h data=%0h exp we=1 addr=%0h data=%0h",
                 i, lg_we(i), lg_addr(i), lg_data(i), a, model_mem[a]);
      end
    end
  endtask

  task automatic test_read_row(input int f, input int r, input int c, input int drop_after,
                               input int expect_n, input int lat);
    int got;
    clear_log();
    resp_lat = lat;
    run_read(f, r, c, drop_after, expect_n, got);
    checks++; if (got != expect_n) begin errors++; $display("FAIL rd_acks c=%0d got %0d exp %0d", c, got, expect_n); end
    checks++; if (log_addr.size() != expect_n) begin errors++; $display("FAIL rd_txn_count got %0d exp %0d", log_addr.size(), expect_n); end
    for (int i = 0; i < expect_n; i++) begin
      int a;
      a = exp_addr(f, r, c + i);
      checks++;
      if (lg_we(i) != 0 || lg_addr(i) != a || rd_at(i) != int'(exp_word(a))) begin
        errors++;
        $display("FAIL rd_word[%0d] got we=%0d addr=%0h data=%0h exp we=0 addr=%0h data=%0h",
                 i, lg_we(i), lg_addr(i), rd_at(i), a, exp_word(a));
      end
    end
  endtask

  task automatic test_random(input int iters);
    for (int it = 0; it < iters; it++) begin
      int f, r, c;
      f = int'($urandom_range(3, 0));
      r = int'($urandom_range(2047, 0));
      c = int'($urandom_range(2047, 0));
      test_write_burst(f, r, c, int'($urandom_range(4, 1)));
      test_read_row(f, r, c, 16, 16, int'($urandom_range(4, 1)));
    end
  endtask

  task automatic test_arbitration();
    int acks, gb, got, rw, cw, rr, cr, rd_base, wr_base;
    rw = int'($urandom_range(2047, 0)); cw = int'($urandom_range(2047, 0));
    rr = int'($urandom_range(2047, 0)); cr = int'($urandom_range(2047, 0));
    do_reset();
    clear_log();
    resp_lat = 2;
    fork
      run_write(2, rw, cw, 0, acks, gb);
      run_read(3, rr, cr, 16, 16, got);
    join
    // After reset the last grant is read: round-robin serves the write first,
    // strict priority serves both read bursts first.
    rd_base = RR ? 16 : 0;
    wr_base = RR ? 0 : 16;
    checks++; if (acks != 16) begin errors++; $display("FAIL arb_wr_acks got %0d exp 16", acks); end
    checks++; if (got != 16)  begin errors++; $display("FAIL arb_rd_acks got %0d exp 16", got); end
    checks++; if (log_addr.size() != 32) begin errors++; $display("FAIL arb_txn_count got %0d exp 32", log_addr.size()); end
    for (int i = 0; i < 16; i++) begin
      int a;
      a = exp_addr(3, rr, cr + i);
      checks++;
      if (lg_we(rd_base + i) != 0 || lg_addr(rd_base + i) != a || rd_at(i) != int'(exp_word(a))) begin
        errors++;
        $display("FAIL arb_rd[%0d] got we=%0d addr=%0h data=%0h exp we=0 addr=%0h data=%0h",
                 i, lg_we(rd_base + i), lg_addr(rd_base + i), rd_at(i), a, exp_word(a));
      end
      a = exp_addr(2, rw, cw + i);
      checks++;
      if (lg_we(wr_base + i) != 1 || lg_addr(wr_base + i) != a || lg_data(wr_base + i) != int'(model_mem[a])) begin
        errors++;
        $display("FAIL arb_wr[%0d] got we=%0d addr=%0h data=%0h exp we=1 addr=%0h data=%0h",
                 i, lg_we(wr_base + i), lg_addr(wr_base + i), lg_data(wr_base + i), a, model_mem[a]);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int seen, events;
    clear_log();
    resp_lat = 50;
    @(negedge clk_sys);
    vidin_frame = 2'd1; vidin_row = 11'd77; vidin_col = 11'd300;
    vidin_d = 16'h1234; vidin_req = 1'b1;
    seen = 0;
    for (int t = 0; t < 30 && seen == 0; t++) begin
      @(negedge clk_sys);
      if (ram_req && ram_we) seen = 1;
    end
    checks++; if (seen != 1) begin errors++; $display("FAIL rst_mid_req_rise got %0d exp 1", seen); end
    reset = 1'b1; vidin_req = 1'b0;
    @(negedge clk_sys);
    checks++; if (ram_req !== 1'b0)   begin errors++; $display("FAIL rst_mid_ram_req got %b exp 0", ram_req); end
    checks++; if (vidin_ack !== 1'b0) begin errors++; $display("FAIL rst_mid_vidin_ack got %b exp 0", vidin_ack); end
    reset = 1'b0;
    events = 0;
    repeat (20) begin
      @(negedge clk_sys);
      if (ram_req || vidin_ack || vidout_ack) events++;
    end
    checks++; if (events != 0) begin errors++; $display("FAIL rst_mid_quiet got %0d events exp 0", events); end
    test_write_burst(1, 77, 300, 2);
  endtask

  task automatic test_stray_ack();
    int ev_in, ev_out, ev_req;
    repeat (3) @(negedge clk_sys);
    stray_req = 1'b1;
    ev_in = 0; ev_out = 0; ev_req = 0;
    repeat (6) begin
      @(negedge clk_sys);
      if (vidin_ack)  ev_in++;
      if (vidout_ack) ev_out++;
      if (ram_req)    ev_req++;
    end
    checks++; if (ev_in != 0)  begin errors++; $display("FAIL stray_vidin_ack got %0d exp 0", ev_in); end
    checks++; if (ev_out != 0) begin errors++; $display("FAIL stray_vidout_ack got %0d exp 0", ev_out); end
    checks++; if (ev_req != 0) begin errors++; $display("FAIL stray_ram_req got %0d exp 0", ev_req); end
    test_read_row(0, 9, 100, 8, 8, 1);
  endtask

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog expired at cycle %0d exp completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_burst(1, 5, 32, 2);
    test_read_row(0, 3, 0, 24, 24, 2);
    test_write_burst(2, 600, 2040, 3);
    test_read_row(2, 600, 2040, 16, 16, 1);
    test_read_row(1, 5, 30, 3, 8, 2);
    test_random(4);
    test_arbitration();
    test_reset_mid_burst();
    test_stray_ack();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
